// File: rtl/regfile_cmd_ctrl.sv
// regfile_cmd_ctrl
//   Command-driven initiator owning the read/write ports of the register file.
//   READ, WRITE, COPY and CLEAR commands arrive over a valid/ready handshake
//   and are sequenced into register-file port activity. READ and COPY results
//   return over a valid/ready response channel.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE, rst low)
//   cmd_op                   00 READ, 01 WRITE, 10 COPY, 11 CLEAR
//   cmd_ra/cmd_rb/cmd_data   command operands
//   rsp_valid/rsp_ready      response handshake
//   rsp_data1/rsp_data2      READ: mem[ra], mem[rb]; COPY: copied value, 0
//   busy                     controller is not in IDLE
//   rf_rreg1/rf_rreg2        register-file read indices
//   rf_wreg/rf_wdata         register-file write index and data
//   rf_regWrite              register-file write enable
//   rf_rdata1/rf_rdata2      combinational register-file read data
//
// Build option
//   REGCTRL_WR_COUNT_EN      adds output wr_count[15:0], a saturating count of
//                            cycles with rf_regWrite high.

module regfile_cmd_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUMOFREGS = 32,
    localparam int unsigned AW       = $clog2(NUMOFREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] rsp_data2,
    output logic             busy,
    output logic [AW-1:0]    rf_rreg1,
    output logic [AW-1:0]    rf_rreg2,
    output logic [AW-1:0]    rf_wreg,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             rf_regWrite,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2
`ifdef REGCTRL_WR_COUNT_EN
    ,
    output logic [15:0]      wr_count
`endif
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CP_RD,
        S_CP_WR,
        S_WR,
        S_CLR,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ra_q, ra_d;
    logic [AW-1:0]    rb_q, rb_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_data1_d, rsp_data2_d;
    logic [AW-1:0]    rf_rreg1_d, rf_rreg2_d, rf_wreg_d;
    logic [WIDTH-1:0] rf_wdata_d;
    logic             rf_regWrite_d;
    logic [AW-1:0]    idx_inc;

    // Handshake/status derived directly from the state register.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign idx_inc   = idx_q + AW'(1);

    // Next-state and next-output logic. Port outputs are registered, so the
    // value presented in a state is computed on the transition into it.
    always_comb begin
        state_d       = state_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        idx_d         = idx_q;
        rsp_valid_d   = rsp_valid;
        rsp_data1_d   = rsp_data1;
        rsp_data2_d   = rsp_data2;
        rf_rreg1_d    = '0;
        rf_rreg2_d    = '0;
        rf_wreg_d     = '0;
        rf_wdata_d    = '0;
        rf_regWrite_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ra_d = cmd_ra;
                    rb_d = cmd_rb;
                    case (cmd_op)
                        OP_READ: begin
                            state_d    = S_RD;
                            rf_rreg1_d = cmd_ra;
                            rf_rreg2_d = cmd_rb;
                        end
                        OP_WRITE: begin
                            state_d       = S_WR;
                            rf_wreg_d     = cmd_ra;
                            rf_wdata_d    = cmd_data;
                            rf_regWrite_d = (cmd_ra != '0);
                        end
                        OP_COPY: begin
                            state_d    = S_CP_RD;
                            rf_rreg1_d = cmd_rb;
                        end
                        OP_CLEAR: begin
                            // An empty range (ra > rb) still spends one cycle, with no write.
                            state_d       = S_CLR;
                            idx_d         = cmd_ra;
                            rf_wreg_d     = cmd_ra;
                            rf_regWrite_d = (cmd_ra != '0) && (cmd_ra <= cmd_rb);
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_RD: begin
                rsp_data1_d = rf_rdata1;
                rsp_data2_d = rf_rdata2;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end

            S_CP_RD: begin
                // rf_wdata doubles as the copy register for the following write cycle.
                rsp_data1_d   = rf_rdata1;
                rsp_data2_d   = '0;
                rf_wreg_d     = ra_q;
                rf_wdata_d    = rf_rdata1;
                rf_regWrite_d = (ra_q != '0);
                state_d       = S_CP_WR;
            end

            S_CP_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end

            S_WR: begin
                state_d = S_IDLE;
            end

            S_CLR: begin
                // Stop on the last row; idx stays below rb while stepping so it cannot wrap.
                if (idx_q >= rb_q) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d         = idx_inc;
                    rf_wreg_d     = idx_inc;
                    rf_regWrite_d = (idx_inc != '0);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            idx_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_data1   <= '0;
            rsp_data2   <= '0;
            rf_rreg1    <= '0;
            rf_rreg2    <= '0;
            rf_wreg     <= '0;
            rf_wdata    <= '0;
            rf_regWrite <= 1'b0;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            idx_q       <= idx_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data1   <= rsp_data1_d;
            rsp_data2   <= rsp_data2_d;
            rf_rreg1    <= rf_rreg1_d;
            rf_rreg2    <= rf_rreg2_d;
            rf_wreg     <= rf_wreg_d;
            rf_wdata    <= rf_wdata_d;
            rf_regWrite <= rf_regWrite_d;
        end
    end

`ifdef REGCTRL_WR_COUNT_EN
    // Saturating count of write-enable cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if (rf_regWrite && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule
